// File: rtl/hash_table_pkg.sv
// ---------------------------------------------------------------------------
// hash_table package
//
// Types shared by the hash table core and its command front-end: command
// and result records, opcode/result enums, plus the default sizing of the
// multi-channel command mux and its channel-id type.
// ---------------------------------------------------------------------------
package hash_table;

    localparam int KEY_WIDTH   = 16;
    localparam int VALUE_WIDTH = 16;

    localparam int CMD_MUX_CHANNELS        = 4;
    localparam int CMD_MUX_MAX_OUTSTANDING = 16;

    typedef logic [$clog2(CMD_MUX_CHANNELS)-1:0] ht_ch_id_t;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_DELETE = 2'd1,
        OP_SEARCH = 2'd2,
        OP_NOP    = 2'd3
    } ht_opcode_t;

    typedef enum logic [2:0] {
        SEARCH_FOUND                     = 3'd0,
        SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd1,
        INSERT_SUCCESS                   = 3'd2,
        INSERT_SUCCESS_SAME_KEY          = 3'd3,
        INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd4,
        DELETE_SUCCESS                   = 3'd5,
        DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        ht_opcode_t             opcode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        ht_opcode_t             cmd;
        ht_rescode_t            rescode;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_result_t;

endpackage

// File: rtl/ht_tag_fifo.sv
// ---------------------------------------------------------------------------
// ht_tag_fifo
//
// Synchronous first-word-fall-through FIFO holding the channel id of every
// command issued to the hash table core but not yet answered. The head entry
// is visible on head_data whenever the FIFO is not empty.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset (pointers and occupancy)
//   push       write push_data (ignored when full)
//   push_data  channel id to record
//   pop        discard the head entry (ignored when empty)
//   head_data  current head entry
//   usedw      occupancy, 0..DEPTH
//   empty      no entries
//   full       DEPTH entries
// ---------------------------------------------------------------------------
module ht_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; only pointers and count must be known, and
    // leaving the array unreset lets it map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign usedw     = count;
    assign empty     = (count == '0);
    assign full      = (count == CNT_MAX);

endmodule

// File: rtl/ht_cmd_mux.sv
// ---------------------------------------------------------------------------
// ht_cmd_mux
//
// Multi-channel command front-end for the hash table core. Arbitrates the
// client command streams onto the single core command port through one
// output register, records the issuing channel of each command in a tag
// FIFO, and routes the in-order results back to that channel.
//
// Configuration macro: HT_CMD_MUX_STRICT_PRIO_EN
//   defined   - fixed priority, lowest channel index wins
//   undefined - round-robin starting after the last granted channel
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   ch_cmd_i          per-channel command
//   ch_cmd_valid_i    per-channel command valid
//   ch_cmd_ready_o    per-channel accept (one-hot winner)
//   ht_cmd_o          registered command to the core
//   ht_cmd_valid_o    command valid to the core
//   ht_cmd_ready_i    core accepts the command
//   ht_res_i          result from the core
//   ht_res_valid_i    result valid from the core
//   ht_res_ready_o    result consumed
//   ch_res_o          result, broadcast to all channels
//   ch_res_valid_o    one-hot result valid for the issuing channel
//   ch_res_ready_i    per-channel result ready
//   outstanding_o     commands issued but not yet answered
//   err_unexp_res_o   sticky: a result arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ht_cmd_mux
    import hash_table::*;
#(
    parameter int CHANNELS        = CMD_MUX_CHANNELS,
    parameter int MAX_OUTSTANDING = CMD_MUX_MAX_OUTSTANDING
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  ht_command_t [CHANNELS-1:0]         ch_cmd_i,
    input  logic [CHANNELS-1:0]                ch_cmd_valid_i,
    output logic [CHANNELS-1:0]                ch_cmd_ready_o,
    output ht_command_t                        ht_cmd_o,
    output logic                               ht_cmd_valid_o,
    input  logic                               ht_cmd_ready_i,
    input  ht_result_t                         ht_res_i,
    input  logic                               ht_res_valid_i,
    output logic                               ht_res_ready_o,
    output ht_result_t                         ch_res_o,
    output logic [CHANNELS-1:0]                ch_res_valid_o,
    input  logic [CHANNELS-1:0]                ch_res_ready_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               err_unexp_res_o
);

    localparam int CH_W = $clog2(CHANNELS);

    logic            can_accept;
    logic            cmd_accept;
    logic            grant_found;
    logic [CH_W-1:0] grant_id;
    logic [CH_W-1:0] tag_head;
    logic            tag_empty;
    logic            tag_full;
    logic            tag_pop;

    // -----------------------------------------------------------------------
    // Arbitration. Loops run from lowest to highest priority so the last
    // matching candidate written is the winner, without a break.
    // -----------------------------------------------------------------------
`ifdef HT_CMD_MUX_STRICT_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_cmd_valid_i[i]) begin
                grant_found = 1'b1;
                grant_id    = CH_W'(i);
            end
        end
    end
`else
    logic [CH_W-1:0] last_grant;

    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        // Offset 1 (the channel right after last_grant) has top priority.
        for (int i = CHANNELS; i >= 1; i--) begin
            if (ch_cmd_valid_i[(int'(last_grant) + i) % CHANNELS]) begin
                grant_found = 1'b1;
                grant_id    = CH_W'((int'(last_grant) + i) % CHANNELS);
            end
        end
    end

    // Reset to the last channel so channel 0 is first in line.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= CH_W'(CHANNELS - 1);
        end else if (cmd_accept) begin
            last_grant <= grant_id;
        end
    end
`endif

    // A pop of the tag FIFO in the same cycle does not free a slot here: the
    // full check uses the registered occupancy only.
    assign can_accept = (!ht_cmd_valid_o || ht_cmd_ready_i) && !tag_full;
    assign cmd_accept = can_accept && grant_found && !rst_i;

    always_comb begin
        ch_cmd_ready_o = '0;
        if (cmd_accept) begin
            ch_cmd_ready_o[grant_id] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Command output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ht_cmd_o       <= '0;
            ht_cmd_valid_o <= 1'b0;
        end else if (cmd_accept) begin
            ht_cmd_o       <= ch_cmd_i[grant_id];
            ht_cmd_valid_o <= 1'b1;
        end else if (ht_cmd_ready_i) begin
            ht_cmd_valid_o <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Issue-order tag FIFO
    // -----------------------------------------------------------------------
    ht_tag_fifo #(
        .WIDTH (CH_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (cmd_accept),
        .push_data (grant_id),
        .pop       (tag_pop),
        .head_data (tag_head),
        .usedw     (outstanding_o),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // -----------------------------------------------------------------------
    // Result routing: combinational and strictly in order. A head channel
    // that is not ready stalls every result behind it.
    // -----------------------------------------------------------------------
    always_comb begin
        ch_res_valid_o = '0;
        ht_res_ready_o = 1'b0;
        if (!rst_i) begin
            if (tag_empty) begin
                // Nobody is waiting: swallow the result so the core never hangs.
                ht_res_ready_o = 1'b1;
            end else begin
                ch_res_valid_o[tag_head] = ht_res_valid_i;
                ht_res_ready_o           = ch_res_ready_i[tag_head];
            end
        end
    end

    assign tag_pop  = ht_res_valid_i && ht_res_ready_o && !tag_empty;
    assign ch_res_o = ht_res_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_unexp_res_o <= 1'b0;
        end else if (ht_res_valid_i && tag_empty) begin
            err_unexp_res_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ht_cmd_mux.sv
// ---------------------------------------------------------------------------
// tb_ht_cmd_mux
//
// Self-checking bench for ht_cmd_mux. The bench plays both the clients and
// the hash table core. A queue-based reference model predicts grants,
// occupancy and result routing; expected commands and results are pushed
// into scoreboard queues and a separate monitor pops and compares them on
// every DUT handshake.
// ---------------------------------------------------------------------------
module tb_ht_cmd_mux;
    import hash_table::*;

    localparam int NCH  = 4;
    localparam int MAXO = 16;

    typedef struct {
        int         ch;
        ht_result_t res;
    } res_item_t;

    logic                      clk = 1'b0;
    logic                      rst_i;
    ht_command_t [NCH-1:0]     ch_cmd_i;
    logic [NCH-1:0]            ch_cmd_valid_i;
    logic [NCH-1:0]            ch_cmd_ready_o;
    ht_command_t               ht_cmd_o;
    logic                      ht_cmd_valid_o;
    logic                      ht_cmd_ready_i;
    ht_result_t                ht_res_i;
    logic                      ht_res_valid_i;
    logic                      ht_res_ready_o;
    ht_result_t                ch_res_o;
    logic [NCH-1:0]            ch_res_valid_o;
    logic [NCH-1:0]            ch_res_ready_i;
    logic [$clog2(MAXO):0]     outstanding_o;
    logic                      err_unexp_res_o;

    always #5 clk = ~clk;

    ht_cmd_mux #(
        .CHANNELS        (NCH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ch_cmd_i        (ch_cmd_i),
        .ch_cmd_valid_i  (ch_cmd_valid_i),
        .ch_cmd_ready_o  (ch_cmd_ready_o),
        .ht_cmd_o        (ht_cmd_o),
        .ht_cmd_valid_o  (ht_cmd_valid_o),
        .ht_cmd_ready_i  (ht_cmd_ready_i),
        .ht_res_i        (ht_res_i),
        .ht_res_valid_i  (ht_res_valid_i),
        .ht_res_ready_o  (ht_res_ready_o),
        .ch_res_o        (ch_res_o),
        .ch_res_valid_o  (ch_res_valid_o),
        .ch_res_ready_i  (ch_res_ready_i),
        .outstanding_o   (outstanding_o),
        .err_unexp_res_o (err_unexp_res_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ht_command_t pending_q[$];   // accepted, still in the output register
    ht_command_t core_q[$];      // taken by the core, awaiting a result
    int          tag_q[$];       // issuing channel of every outstanding command
    ht_command_t cmd_exp[$];     // scoreboard: commands the core must see
    res_item_t   res_exp[$];     // scoreboard: results the clients must see
    int          rr_last;
    bit          err_exp;

    // Stimulus knobs
    logic [NCH-1:0] req_valid;
    ht_command_t    req_cmd [NCH];
    bit             core_ready;
    bit             res_en;
    bit             res_pending;
    bit             force_unexp;
    ht_result_t     res_data;
    logic [NCH-1:0] res_rdy;
    int             last_win;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ht_command_t rand_cmd();
        ht_command_t c;
        c.opcode = ht_opcode_t'($urandom_range(0, 2));
        c.key    = 16'($urandom);
        c.value  = 16'($urandom);
        return c;
    endfunction

    // Behaviour of the pretend core: echo key, scramble value.
    function automatic ht_result_t make_res(input ht_command_t c);
        ht_result_t r;
        r.cmd   = c.opcode;
        r.key   = c.key;
        r.value = c.value ^ 16'hA5A5;
        case (c.opcode)
            OP_SEARCH: r.rescode = c.key[0] ? SEARCH_NOT_SUCCESS_NO_ENTRY : SEARCH_FOUND;
            OP_INSERT: r.rescode = INSERT_SUCCESS;
            default:   r.rescode = DELETE_SUCCESS;
        endcase
        return r;
    endfunction

    function automatic int expected_winner();
`ifdef HT_CMD_MUX_STRICT_PRIO_EN
        for (int c = 0; c < NCH; c++) begin
            if (req_valid[c]) return c;
        end
`else
        for (int k = 1; k <= NCH; k++) begin
            if (req_valid[(rr_last + k) % NCH]) return (rr_last + k) % NCH;
        end
`endif
        return -1;
    endfunction

    task automatic refill(input logic [NCH-1:0] mask);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && !req_valid[c]) begin
                req_valid[c] = 1'b1;
                req_cmd[c]   = rand_cmd();
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        pending_q.delete();
        core_q.delete();
        tag_q.delete();
        cmd_exp.delete();
        res_exp.delete();
        rr_last     = NCH - 1;
        err_exp     = 1'b0;
        res_pending = 1'b0;
        force_unexp = 1'b0;
        req_valid   = '0;
        // Busy inputs while in reset: handshake outputs must still be 0.
        ch_cmd_valid_i = '1;
        ht_cmd_ready_i = 1'b1;
        ht_res_valid_i = 1'b1;
        ch_res_ready_i = '1;
        #1;
        check("rst_cmd_valid", ht_cmd_valid_o, 0);
        check("rst_cmd_data", ht_cmd_o, 0);
        check("rst_ch_cmd_ready", ch_cmd_ready_o, 0);
        check("rst_ch_res_valid", ch_res_valid_o, 0);
        check("rst_res_ready", ht_res_ready_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_unexp_res_o, 0);
        repeat (2) @(negedge clk);
        rst_i          = 1'b0;
        ch_cmd_valid_i = '0;
        ht_cmd_ready_i = 1'b0;
        ht_res_valid_i = 1'b0;
        ch_res_ready_i = '0;
    endtask

    // One clock cycle: drive inputs at the falling edge, check combinational
    // and registered outputs against the model, then advance the model.
    task automatic cycle();
        int             win;
        bit             can_acc;
        logic [NCH-1:0] exp_ready;
        logic [NCH-1:0] exp_rv;
        logic           exp_rr;
        res_item_t      item;
        @(negedge clk);
        if (res_en && !res_pending && core_q.size() > 0) begin
            res_data    = make_res(core_q[0]);
            res_pending = 1'b1;
        end
        for (int c = 0; c < NCH; c++) begin
            ch_cmd_i[c] = req_cmd[c];
        end
        ch_cmd_valid_i = req_valid;
        ht_cmd_ready_i = core_ready;
        ht_res_valid_i = res_pending || force_unexp;
        ht_res_i       = res_data;
        ch_res_ready_i = res_rdy;
        #1;
        check("outstanding", outstanding_o, tag_q.size());
        check("cmd_valid", ht_cmd_valid_o, pending_q.size() > 0);
        if (pending_q.size() > 0) check("cmd_data", ht_cmd_o, pending_q[0]);
        check("err_flag", err_unexp_res_o, err_exp);

        can_acc   = (pending_q.size() == 0 || core_ready) && tag_q.size() < MAXO;
        win       = expected_winner();
        exp_ready = '0;
        if (can_acc && win >= 0) exp_ready[win] = 1'b1;
        check("ch_cmd_ready", ch_cmd_ready_o, exp_ready);

        exp_rv = '0;
        if (tag_q.size() > 0) begin
            exp_rr            = res_rdy[tag_q[0]];
            exp_rv[tag_q[0]]  = ht_res_valid_i;
        end else begin
            exp_rr = 1'b1;
        end
        check("res_ready", ht_res_ready_o, exp_rr);
        check("ch_res_valid", ch_res_valid_o, exp_rv);

        if (ht_res_valid_i && exp_rr) begin
            if (tag_q.size() > 0) begin
                item.ch  = tag_q.pop_front();
                item.res = res_data;
                res_exp.push_back(item);
                void'(core_q.pop_front());
                res_pending = 1'b0;
            end else begin
                err_exp = 1'b1;
            end
        end
        if (pending_q.size() > 0 && core_ready) begin
            core_q.push_back(pending_q.pop_front());
        end
        if (exp_ready != '0) begin
            pending_q.push_back(req_cmd[win]);
            cmd_exp.push_back(req_cmd[win]);
            tag_q.push_back(win);
            rr_last        = win;
            req_valid[win] = 1'b0;
            last_win       = win;
        end else begin
            last_win = -1;
        end
    endtask

    // Monitor: pops the scoreboards on every DUT handshake.
    initial begin
        int        ch;
        res_item_t item;
        forever begin
            @(negedge clk);
            #3;
            if (ht_cmd_valid_o && ht_cmd_ready_i) begin
                if (cmd_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL cmd_sb: got command 0x%0h, expected none", ht_cmd_o);
                end else begin
                    check("cmd_sb", ht_cmd_o, cmd_exp.pop_front());
                end
            end
            if ((ch_res_valid_o & ch_res_ready_i) != '0) begin
                check("res_onehot", $countones(ch_res_valid_o), 1);
                ch = -1;
                for (int c = NCH - 1; c >= 0; c--) begin
                    if (ch_res_valid_o[c] && ch_res_ready_i[c]) ch = c;
                end
                if (res_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_sb: got result on channel %0d, expected none", ch);
                end else begin
                    item = res_exp.pop_front();
                    check("res_sb_channel", ch, item.ch);
                    check("res_sb_data", ch_res_o, item.res);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants [8];
        int          prio_exp;
        ht_command_t held;
        int          thresh;

        rst_i          = 1'b1;
        ch_cmd_valid_i = '0;
        ch_cmd_i       = '0;
        ht_cmd_ready_i = 1'b0;
        ht_res_valid_i = 1'b0;
        ht_res_i       = '0;
        ch_res_ready_i = '0;
        res_data       = '0;
        core_ready     = 1'b1;
        res_en         = 1'b0;
        res_rdy        = '1;
        for (int c = 0; c < NCH; c++) req_cmd[c] = '0;

        // Single SEARCH from channel 0, result back on channel 0 only.
        do_reset();
        req_cmd[0] = '{opcode: OP_SEARCH, key: 16'h1234, value: 16'h0042};
        req_valid  = 4'b0001;
        cycle();
        check("t1_grant", last_win, 0);
        cycle();
        check("t1_valid", ht_cmd_valid_o, 1);
        check("t1_key", ht_cmd_o.key, 16'h1234);
        res_en = 1'b1;
        cycle();
        check("t1_res_route", ch_res_valid_o, 4'b0001);
        check("t1_rescode", ch_res_o.rescode, SEARCH_FOUND);
        cycle();

        // All channels valid, no results: grant order and occupancy.
        do_reset();
        res_en = 1'b0;
        for (int n = 0; n < 8; n++) begin
            refill('1);
            cycle();
            grants[n] = last_win;
        end
        for (int n = 0; n < 8; n++) begin
`ifdef HT_CMD_MUX_STRICT_PRIO_EN
            check($sformatf("t2_grant%0d", n), grants[n], 0);
`else
            check($sformatf("t2_grant%0d", n), grants[n], n % NCH);
`endif
        end
        req_valid = '0;
        cycle();
        check("t2_outstanding8", outstanding_o, 8);

        // Fill to MAX_OUTSTANDING, then free one slot with a result.
        for (int n = 0; n < 8; n++) begin
            refill('1);
            cycle();
        end
        refill('1);
        cycle();
        check("t3_full_ready", ch_cmd_ready_o, 0);
        check("t3_outstanding16", outstanding_o, 16);
        res_en = 1'b1;
        cycle();
        check("t3_pop_no_relax", ch_cmd_ready_o, 0);
        res_en = 1'b0;
        cycle();
        check("t3_accept_after_pop", ch_cmd_ready_o != '0, 1);
        cycle();

        // Core stalls for 5 cycles: output held, nothing accepted.
        do_reset();
        req_cmd[3] = rand_cmd();
        held       = req_cmd[3];
        req_valid  = 4'b1000;
        core_ready = 1'b0;
        cycle();
        for (int n = 0; n < 5; n++) begin
            refill('1);
            cycle();
            check($sformatf("t4_hold%0d", n), ht_cmd_o, held);
            check($sformatf("t4_noready%0d", n), ch_cmd_ready_o, 0);
        end
        core_ready = 1'b1;
        req_valid  = '0;
        cycle();
        cycle();

        // Head-of-line blocking: ch2 result stalls the ch1 result.
        do_reset();
        req_cmd[2] = rand_cmd();
        req_valid  = 4'b0100;
        cycle();
        req_cmd[1] = rand_cmd();
        req_valid  = 4'b0010;
        cycle();
        cycle();
        res_en  = 1'b1;
        res_rdy = 4'b1011;
        for (int n = 0; n < 3; n++) begin
            cycle();
            check($sformatf("t5_blocked%0d", n), ht_res_ready_o, 0);
            check($sformatf("t5_ch1_idle%0d", n), ch_res_valid_o[1], 0);
        end
        res_rdy = '1;
        cycle();
        check("t5_ch2_first", ch_res_valid_o, 4'b0100);
        cycle();
        check("t5_ch1_second", ch_res_valid_o, 4'b0010);

        // Channels 1 and 3 contending.
        do_reset();
        for (int n = 0; n < 6; n++) begin
            refill(4'b1010);
            cycle();
`ifdef HT_CMD_MUX_STRICT_PRIO_EN
            prio_exp = 1;
`else
            prio_exp = (n % 2 == 0) ? 1 : 3;
`endif
            check($sformatf("t6_grant%0d", n), last_win, prio_exp);
        end

        // Randomized traffic, first with slow then fast result return.
        do_reset();
        for (int seg = 0; seg < 2; seg++) begin
            thresh = (seg == 0) ? 2 : 6;
            for (int n = 0; n < 1000; n++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!req_valid[c] && ($urandom % 2 == 0)) begin
                        req_valid[c] = 1'b1;
                        req_cmd[c]   = rand_cmd();
                    end
                    res_rdy[c] = ($urandom % 4) != 0;
                end
                core_ready = ($urandom % 4) != 0;
                res_en     = ($urandom % 8) < thresh;
                cycle();
            end
        end
        req_valid  = '0;
        core_ready = 1'b1;
        res_en     = 1'b1;
        res_rdy    = '1;
        repeat (60) cycle();
        #5;
        check("drain_outstanding", outstanding_o, 0);
        check("drain_cmd_sb", cmd_exp.size(), 0);
        check("drain_res_sb", res_exp.size(), 0);

        // Result with nothing outstanding: dropped, sticky error until reset.
        do_reset();
        res_en      = 1'b0;
        res_data    = make_res(rand_cmd());
        force_unexp = 1'b1;
        cycle();
        check("t7_dropped_ready", ht_res_ready_o, 1);
        check("t7_no_delivery", ch_res_valid_o, 0);
        force_unexp = 1'b0;
        repeat (4) cycle();
        check("t7_err_sticky", err_unexp_res_o, 1);
        do_reset();
        cycle();
        check("t7_err_cleared", err_unexp_res_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
